// File: rtl/debounce_bank.sv
// ----------------------------------------------------------------------------
// debounce_bank
//   N-channel button/switch conditioner. Each channel:
//     - optional input inversion (INVERT bit), so active-low buttons read as
//       1 = pressed downstream,
//     - 2-FF synchroniser,
//     - counter-based debounce (COUNT_MAX consecutive disagreeing samples
//       flip the level; any agreeing sample restarts the count),
//     - registered 1-cycle press / release strobes that coincide with the
//       first cycle the new level is visible.
//   Channels are fully independent; there is no arbitration between them.
//
//   Optional feature, macro DEBOUNCE_BANK_REPEAT_EN:
//     hold-to-repeat. While a channel stays pressed, btn_press re-fires after
//     REPEAT_DELAY held cycles and then every REPEAT_PERIOD cycles. Without the
//     macro no hold counters exist and btn_press is edge-only.
//
// Parameters
//   N             channels (1..32)
//   COUNT_MAX     stable synced cycles required for a level change (>=2)
//   INVERT        per-channel: 1 = raw input is active-low
//   REPEAT_DELAY  held cycles before first repeat strobe (>=1)
//   REPEAT_PERIOD held cycles between later repeat strobes (>=1)
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   btn_in       in   [N] raw asynchronous inputs
//   btn_level    out  [N] debounced level (1 = pressed)
//   btn_press    out  [N] 1-cycle strobe on 0->1 (plus repeats if enabled)
//   btn_release  out  [N] 1-cycle strobe on 1->0
// ----------------------------------------------------------------------------

// Single channel: sync, debounce, strobes, optional hold-repeat.
module debounce_lane #(
  parameter int unsigned COUNT_MAX     = 500000,
  parameter logic        INVERT        = 1'b0
`ifdef DEBOUNCE_BANK_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(COUNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);

  logic          r_s0, r_s1;
  logic          r_level, r_press, r_release;
  logic [CW-1:0] r_cnt;

  logic w_mismatch, w_flip, w_rise, w_fall, w_rep_hit;

  assign w_mismatch = (r_s1 != r_level);
  // The COUNT_MAX-th consecutive disagreeing sample commits the new level.
  assign w_flip     = w_mismatch && (r_cnt == CNT_LAST);
  assign w_rise     = w_flip &  r_s1;
  assign w_fall     = w_flip & ~r_s1;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RMAX + 1);
  localparam logic [HW-1:0] RD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] r_hc;
  logic          r_repeating;   // first repeat already issued -> use period

  // A level flip (edge press or release) in the same cycle always wins.
  assign w_rep_hit = r_level && !w_flip &&
                     (r_hc == (r_repeating ? RP_LAST : RD_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc        <= '0;
      r_repeating <= 1'b0;
    end else if (w_flip || !r_level) begin
      r_hc        <= '0;
      r_repeating <= 1'b0;
    end else if (w_rep_hit) begin
      r_hc        <= '0;
      r_repeating <= 1'b1;
    end else begin
      r_hc        <= r_hc + 1'b1;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // Inversion ahead of the sync so an idle active-low input already
      // matches the reset value of the synchroniser.
      r_s0      <= i_btn ^ INVERT;
      r_s1      <= r_s0;
      r_press   <= w_rise | w_rep_hit;
      r_release <= w_fall;
      if (!w_mismatch) begin
        r_cnt   <= '0;
      end else if (w_flip) begin
        r_level <= r_s1;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

module debounce_bank #(
  parameter int unsigned N             = 4,
  parameter int unsigned COUNT_MAX     = 500000,
  parameter logic [N-1:0] INVERT       = '0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  // Reject configurations the counters cannot represent.
  generate
    if (N < 1 || N > 32 || COUNT_MAX < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("debounce_bank: illegal parameter combination");
    end
  endgenerate

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    debounce_lane #(
      .COUNT_MAX     (COUNT_MAX),
      .INVERT        (INVERT[gi])
`ifdef DEBOUNCE_BANK_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_btn     (btn_in[gi]),
      .o_level   (btn_level[gi]),
      .o_press   (btn_press[gi]),
      .o_release (btn_release[gi])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int N  = 4;
  localparam int CM = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [N-1:0] INV = 4'b1000;
`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] btn_in = 4'b1000;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N(N), .COUNT_MAX(CM), .INVERT(INV), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  // ---------------- reference model ----------------
  // Logical input seen by the debouncer at edge k is the value present two
  // edges earlier. The level follows the sample stream once a run of equal
  // samples that disagrees with the level reaches CM long.
  logic [N-1:0] m_h1, m_h2, m_last, m_lvl, m_press, m_rel;
  int m_run  [N];
  int m_held [N];   // edges since level went high

  function automatic int run_len(bit s, bit last, int r);
    return (s == last) ? r + 1 : 1;
  endfunction

  function automatic bit rep_hit(int h);
    return (h == RD) || (h > RD && ((h - RD) % RP) == 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_h1 <= '0; m_h2 <= '0; m_last <= '0;
      m_lvl <= '0; m_press <= '0; m_rel <= '0;
      for (int i = 0; i < N; i++) begin
        m_run[i]  <= 0;
        m_held[i] <= 0;
      end
    end else begin
      m_h1   <= btn_in ^ INV;
      m_h2   <= m_h1;
      m_last <= m_h2;
      for (int i = 0; i < N; i++) begin
        m_run[i] <= run_len(m_h2[i], m_last[i], m_run[i]);
        if (m_h2[i] != m_lvl[i] && run_len(m_h2[i], m_last[i], m_run[i]) >= CM) begin
          m_lvl[i]   <= m_h2[i];
          m_press[i] <= m_h2[i];
          m_rel[i]   <= ~m_h2[i];
          m_held[i]  <= 0;
        end else if (m_lvl[i]) begin
          m_held[i]  <= m_held[i] + 1;
          m_press[i] <= REP && rep_hit(m_held[i] + 1);
          m_rel[i]   <= 1'b0;
        end else begin
          m_held[i]  <= 0;
          m_press[i] <= 1'b0;
          m_rel[i]   <= 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl/press/rel %b/%b/%b want all 0", btn_level, btn_press, btn_release);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got lvl/press/rel %b/%b/%b want all 0", k, btn_level, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_clean_press();
    int nrel;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL clean_press_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (k == 5) begin
        n_checks++;
        if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL clean_press_early: level0 got %b want 0 at t+5", btn_level[0]); end
      end
      if (k == 6) begin
        n_checks++;
        if ({btn_level[0], btn_press} !== {1'b1, 4'b0001}) begin
          n_fail++; $display("FAIL clean_press_t6: level0/press got %b/%b want 1/0001", btn_level[0], btn_press);
        end
      end
      if (k == 7) begin
        n_checks++;
        if ({btn_level[0], btn_press[0]} !== 2'b10) begin
          n_fail++; $display("FAIL clean_press_t7: level0/press0 got %b/%b want 1/0", btn_level[0], btn_press[0]);
        end
      end
    end
    btn_in[0] = 1'b0;
    nrel = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      nrel += int'(btn_release[0]);
      if (k == 6) begin
        n_checks++;
        if ({btn_level[0], btn_release} !== {1'b0, 4'b0001}) begin
          n_fail++; $display("FAIL clean_release_t6: level0/release got %b/%b want 0/0001", btn_level[0], btn_release);
        end
      end
    end
    n_checks++;
    if (nrel !== 1) begin n_fail++; $display("FAIL clean_release_count: got %0d want 1", nrel); end
  endtask

  task automatic test_bounce();
    bit pat [20] = '{1,0,1,1,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
    int npress;
    npress = 0;
    for (int k = 0; k < 20; k++) begin
      btn_in[1] = pat[k];
      step();
      npress += int'(btn_press[1]);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL bounce_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
    end
    n_checks++;
    if (npress !== 1 || btn_level[1] !== 1'b1) begin
      n_fail++; $display("FAIL bounce_press: presses %0d level1 %b want 1 / 1", npress, btn_level[1]);
    end
    btn_in[1] = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_active_low();
    int np, nr;
    np = 0; nr = 0;
    btn_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      np += int'(btn_press[3]);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL active_low_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
    end
    n_checks++;
    if (np !== 1 || btn_level !== 4'b1000) begin
      n_fail++; $display("FAIL active_low_press: presses %0d level %b want 1 / 1000", np, btn_level);
    end
    btn_in[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      nr += int'(btn_release[3]);
    end
    n_checks++;
    if (nr !== 1 || btn_level !== 4'b0000) begin
      n_fail++; $display("FAIL active_low_release: releases %0d level %b want 1 / 0000", nr, btn_level);
    end
  endtask

  task automatic test_simultaneous_reset();
    btn_in[0] = 1'b1; btn_in[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) begin
        n_checks++;
        if (btn_press !== 4'b0101) begin n_fail++; $display("FAIL simultaneous_press: got %b want 0101", btn_press); end
      end
    end
    btn_in[0] = 1'b0;   // ch2 stays held so reset has a level to clear
    repeat (10) step();
    btn_in[1] = 1'b1;
    repeat (4) step();  // ch1 counter mid-way
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      n_fail++; $display("FAIL reset_midcount: got %b/%b/%b want all 0", btn_level, btn_press, btn_release);
    end
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (btn_level !== ((k >= 6) ? 4'b0110 : 4'b0000) ||
          btn_press !== ((k == 6) ? 4'b0110 : 4'b0000)) begin
        n_fail++; $display("FAIL after_reset cyc %0d: level/press got %b/%b", k, btn_level, btn_press);
      end
    end
    btn_in[1] = 1'b0; btn_in[2] = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_repeat();
    int np, nr;
    np = 0; nr = 0;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      np += int'(btn_press[0]);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL repeat_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (k == 16) begin
        n_checks++;
        if (btn_press[0] !== REP) begin n_fail++; $display("FAIL repeat_first: press0 got %b want %b", btn_press[0], REP); end
      end
    end
    n_checks++;
    if (np !== (REP ? 8 : 1)) begin n_fail++; $display("FAIL repeat_count: got %0d want %0d", np, REP ? 8 : 1); end
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      nr += int'(btn_release[0]);
      if (k > 6) begin
        n_checks++;
        if (btn_press[0] !== 1'b0) begin n_fail++; $display("FAIL repeat_after_release cyc %0d: press0 got 1 want 0", k); end
      end
    end
    n_checks++;
    if (nr !== 1) begin n_fail++; $display("FAIL repeat_release_count: got %0d want 1", nr); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6) == 0) btn_in[i] = ~btn_in[i];
      step();
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel} ||
          (btn_press & btn_release) !== 4'b0000) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_active_low();
    test_simultaneous_reset();
    test_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
